// File: rtl/simon_draw_pkg.sv
// Shared drawing constants, screen geometry and plotter state encoding
// for the Simon Says display path between the game FSM and the VGA adapter.
package simon_draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [C_W-1:0] WHITE = 3'b111;
    localparam logic [C_W-1:0] GREEN = 3'b010;
    localparam logic [C_W-1:0] BLACK = 3'b000;

    localparam logic [X_W-1:0] UP_X    = 8'd78;
    localparam logic [Y_W-1:0] UP_Y    = 7'd54;
    localparam logic [X_W-1:0] DOWN_X  = 8'd78;
    localparam logic [Y_W-1:0] DOWN_Y  = 7'd62;
    localparam logic [X_W-1:0] LEFT_X  = 8'd74;
    localparam logic [Y_W-1:0] LEFT_Y  = 7'd58;
    localparam logic [X_W-1:0] RIGHT_X = 8'd82;
    localparam logic [Y_W-1:0] RIGHT_Y = 7'd58;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        CLEAR,
        DONE
    } plot_state_e;

endpackage

// File: rtl/square_plotter_xy_scan_counter.sv
// 2-D raster counter: x runs 0..x_max_i (inner), y runs 0..y_max_i (outer).
// Ports: clock/reset_n, clr_i (sync zero), en_i (step), limits, x_o/y_o, last_o.
module xy_scan_counter #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [XW-1:0] x_max_i,
    input  logic [YW-1:0] y_max_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic x_end;
    logic y_end;

    assign x_end  = (x_q == x_max_i);
    assign y_end  = (y_q == y_max_i);
    assign last_o = x_end && y_end;
    assign x_o    = x_q;
    assign y_o    = y_q;

    // Wraps to (0,0) after the last point so the next scan starts clean.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/square_plotter.sv
// Rasterises a SIZE x SIZE filled square (or a full-screen black clear)
// onto the VGA adapter write port, one pixel per clock, with start/busy/done.
// Ports: start/clear/in_x/in_y/in_color requests; busy/done status;
// vga_x/vga_y/vga_colour/plot adapter write port.
module square_plotter
    import simon_draw_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int SCREEN_W = simon_draw_pkg::SCREEN_W,
    parameter int SCREEN_H = simon_draw_pkg::SCREEN_H
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic           clear,
    input  logic [X_W-1:0] in_x,
    input  logic [Y_W-1:0] in_y,
    input  logic [C_W-1:0] in_color,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           plot
);

    localparam logic [X_W-1:0] SQ_XM  = X_W'(SIZE - 1);
    localparam logic [Y_W-1:0] SQ_YM  = Y_W'(SIZE - 1);
    localparam logic [X_W-1:0] CLR_XM = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] CLR_YM = Y_W'(SCREEN_H - 1);
    localparam logic [X_W:0]   X_LIM  = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(SCREEN_H);

    plot_state_e state_q, state_d;

    logic [X_W-1:0] base_x_q, base_x_d;
    logic [Y_W-1:0] base_y_q, base_y_d;
    logic [C_W-1:0] color_q, color_d;

    logic           cnt_clr;
    logic           cnt_en;
    logic [X_W-1:0] cnt_x;
    logic [Y_W-1:0] cnt_y;
    logic           cnt_last;
    logic [X_W-1:0] lim_x;
    logic [Y_W-1:0] lim_y;

    // One extra bit so sums past the screen edge are caught, not wrapped.
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;

    assign lim_x = (state_q == CLEAR) ? CLR_XM : SQ_XM;
    assign lim_y = (state_q == CLEAR) ? CLR_YM : SQ_YM;
    assign x_sum = {1'b0, base_x_q} + {1'b0, cnt_x};
    assign y_sum = {1'b0, base_y_q} + {1'b0, cnt_y};

    xy_scan_counter #(
        .XW (X_W),
        .YW (Y_W)
    ) u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .x_max_i (lim_x),
        .y_max_i (lim_y),
        .x_o     (cnt_x),
        .y_o     (cnt_y),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        color_d  = color_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    cnt_clr = 1'b1;
                end else if (start) begin
                    state_d  = DRAW;
                    base_x_d = in_x;
                    base_y_d = in_y;
                    color_d  = in_color;
                    cnt_clr  = 1'b1;
                end
            end
            DRAW, CLEAR: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        plot       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        unique case (state_q)
            DRAW: begin
                busy       = 1'b1;
                vga_x      = x_sum[X_W-1:0];
                vga_y      = y_sum[Y_W-1:0];
                vga_colour = color_q;
                plot       = (x_sum < X_LIM) && (y_sum < Y_LIM);
            end
            CLEAR: begin
                busy  = 1'b1;
                vga_x = cnt_x;
                vga_y = cnt_y;
                plot  = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            base_x_q <= '0;
            base_y_q <= '0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            color_q  <= color_d;
        end
    end

endmodule

// File: tb/tb_square_plotter.sv
// Directed bench for square_plotter: table of square requests with
// hand-computed plot counts, plus clear, priority and reset sequences.
module tb_square_plotter;

    localparam int SIZE = 4;
    localparam int SW   = 160;
    localparam int SH   = 120;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       clear;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_color;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    int checks = 0;
    int errors = 0;

    square_plotter #(
        .SIZE     (SIZE),
        .SCREEN_W (SW),
        .SCREEN_H (SH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .clear      (clear),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_color   (in_color),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         plots;
        bit         poke;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] outs();
        return {busy, done, plot, vga_x, vga_y, vga_colour};
    endfunction

    // Draw one square and check every cycle, the plot count and done timing.
    task automatic run_square(input vec_t v);
        int          xs, ys, plotted;
        logic [20:0] exp;
        in_x     = v.x;
        in_y     = v.y;
        in_color = v.c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_x     = ~v.x;
        in_y     = ~v.y;
        in_color = ~v.c;
        plotted  = 0;
        for (int i = 0; i < SIZE * SIZE; i++) begin
            xs  = int'(v.x) + i % SIZE;
            ys  = int'(v.y) + i / SIZE;
            exp = {1'b1, 1'b0, (xs < SW && ys < SH),
                   8'(xs & 255), 7'(ys & 127), v.c};
            check("draw_pixel", 32'(outs()), 32'(exp));
            if (plot) plotted++;
            start = (v.poke && i == 5);
            tick();
        end
        start = 1'b0;
        check("done_cycle", 32'(outs()), 32'(21'b01 << 19));
        check("plot_count", plotted, v.plots);
        start = v.poke;
        tick();
        start = 1'b0;
        check("after_done", 32'(outs()), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{8'd78,  7'd54,  3'b111, 16, 1'b0};
        vecs[1] = '{8'd158, 7'd118, 3'b010, 4,  1'b1};
        vecs[2] = '{8'd0,   7'd0,   3'b101, 16, 1'b0};
        vecs[3] = '{8'd157, 7'd0,   3'b011, 12, 1'b1};
        vecs[4] = '{8'd0,   7'd117, 3'b001, 12, 1'b0};
        vecs[5] = '{8'd255, 7'd127, 3'b100, 0,  1'b0};

        reset_n  = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_color = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        check("reset_outs", 32'(outs()), 32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (plot || busy || done) n++;
        end
        check("idle_quiet", n, 0);

        foreach (vecs[i]) run_square(vecs[i]);

        // clear and start together: clear wins; pokes during scan ignored
        in_x     = 8'd10;
        in_y     = 7'd10;
        in_color = 3'b111;
        start    = 1'b1;
        clear    = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < SW * SH; i++) begin
            check("clear_pixel", 32'(outs()),
                  32'({1'b1, 1'b0, 1'b1, 8'(i % SW), 7'(i / SW), 3'b000}));
            start = (i >= 100 && i < 103);
            clear = (i == 200);
            tick();
        end
        start = 1'b0;
        clear = 1'b0;
        check("clear_done", 32'(outs()), 32'(21'b01 << 19));
        tick();
        check("clear_after", 32'(outs()), 32'd0);

        // reset during the 7th pixel aborts without a done pulse
        in_x     = 8'd10;
        in_y     = 7'd10;
        in_color = 3'b110;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pixel7", 32'(outs()),
              32'({1'b1, 1'b0, 1'b1, 8'd12, 7'd11, 3'b110}));
        reset_n = 1'b0;
        tick();
        check("abort_outs", 32'(outs()), 32'd0);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (plot || busy || done) n++;
        end
        check("abort_quiet", n, 0);
        run_square(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
